// File: rtl/tetris_pkg.sv
// Shared Tetris playfield dimensions, line-clear FSM encoding and scoring table.
package tetris_pkg;

    localparam int TETRIS_ROWS = 20;
    localparam int TETRIS_COLS = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Points for clearing cnt rows in one pass: 0,1,3,5,8 then +2 per extra row.
    function automatic logic [7:0] line_points(input logic [4:0] cnt);
        case (cnt)
            5'd0:    return 8'd0;
            5'd1:    return 8'd1;
            5'd2:    return 8'd3;
            5'd3:    return 8'd5;
            default: return 8'd8 + 8'({cnt - 5'd4, 1'b0});
        endcase
    endfunction

endpackage

// File: rtl/tetris_line_clear.sv
// Removes full rows from a locked playfield one row per clock and compacts survivors downward.
// done pulses ROWS+2 cycles after start is accepted; start is ignored (not queued) while busy.
module tetris_line_clear
    import tetris_pkg::*;
#(
    parameter int ROWS    = TETRIS_ROWS,
    parameter int COLS    = TETRIS_COLS,
    parameter int SCORE_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 score_clr,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] board_out,
    output logic [4:0]           lines_cleared,
    output logic [SCORE_W-1:0]   score
);

    localparam int RI = $clog2(ROWS);
    localparam int WW = RI + 1;
    localparam int SW = SCORE_W + 6;

    logic [1:0]      state;
    logic [COLS-1:0] work [ROWS];
    logic [COLS-1:0] filled [ROWS];
    logic [ROWS*COLS-1:0] filled_flat;
    logic [RI-1:0]   rd;
    logic [WW-1:0]   wr;   // one bit wider so it can reach -1 when nothing is cleared
    logic [4:0]      cnt;
    logic [COLS-1:0] rd_row;
    logic            row_full;
    logic [SW-1:0]   score_sum;
    logic [SW-1:0]   score_max;
    logic [SCORE_W-1:0] score_next;

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign rd_row   = work[rd];
    assign row_full = &rd_row;

    // Rows at or above the final write pointer were vacated by removed rows.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            filled[i] = work[i];
            if (!wr[WW-1] && (WW'(i) <= wr)) begin
                filled[i] = '0;
            end
            filled_flat[i*COLS +: COLS] = filled[i];
        end
    end

    assign score_sum  = SW'(score) + SW'(line_points(cnt));
    assign score_max  = SW'((1 << SCORE_W) - 1);
    assign score_next = (score_sum > score_max) ? score_max[SCORE_W-1:0] : score_sum[SCORE_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            rd            <= '0;
            wr            <= '0;
            cnt           <= '0;
            board_out     <= '0;
            lines_cleared <= '0;
            score         <= '0;
            for (int i = 0; i < ROWS; i++) begin
                work[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (score_clr) begin
                        score <= '0;
                    end
                    if (start) begin
                        for (int i = 0; i < ROWS; i++) begin
                            work[i] <= board_in[i*COLS +: COLS];
                        end
                        rd    <= RI'(ROWS - 1);
                        wr    <= WW'(ROWS - 1);
                        cnt   <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (row_full) begin
                        cnt <= cnt + 5'd1;
                    end else begin
                        work[wr[RI-1:0]] <= rd_row;
                        wr               <= wr - WW'(1);
                    end
                    rd <= rd - RI'(1);
                    if (rd == '0) begin
                        state <= ST_FILL;
                    end
                end
                // Results are registered here so they are already valid while done is high.
                ST_FILL: begin
                    for (int i = 0; i < ROWS; i++) begin
                        work[i] <= filled[i];
                    end
                    board_out     <= filled_flat;
                    lines_cleared <= cnt;
                    score         <= score_next;
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_line_clear.sv
// Scoreboard bench for tetris_line_clear: expected results are queued at start and checked on done.
module tb_tetris_line_clear;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int N    = ROWS * COLS;
    localparam int SMAX = 127;

    typedef struct {
        logic [N-1:0] board;
        int           lines;
        int           score;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         score_clr = 1'b0;
    logic [N-1:0] board_in = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] board_out;
    logic [4:0]   lines_cleared;
    logic [6:0]   score;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   score_model = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    tetris_line_clear #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(7)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .score_clr     (score_clr),
        .board_in      (board_in),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .score         (score)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int points(input int c);
        int tbl[5] = '{0, 1, 3, 5, 8};
        if (c <= 4) return tbl[c];
        return 8 + 2 * (c - 4);
    endfunction

    // Reference: survivors keep their order and settle at the bottom.
    function automatic exp_t model(input logic [N-1:0] b);
        exp_t e;
        int   dst;
        logic [COLS-1:0] row;
        e.board = '0;
        e.lines = 0;
        dst = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            row = b[r*COLS +: COLS];
            if (row == {COLS{1'b1}}) begin
                e.lines++;
            end else begin
                e.board[dst*COLS +: COLS] = row;
                dst--;
            end
        end
        e.score = 0;
        return e;
    endfunction

    function automatic logic [N-1:0] set_row(input logic [N-1:0] b, input int r, input logic [COLS-1:0] v);
        logic [N-1:0] o;
        o = b;
        o[r*COLS +: COLS] = v;
        return o;
    endfunction

    task automatic push_exp(input logic [N-1:0] b, input bit clr);
        exp_t e;
        e = model(b);
        if (clr) score_model = 0;
        score_model = score_model + points(e.lines);
        if (score_model > SMAX) score_model = SMAX;
        e.score = score_model;
        exp_q.push_back(e);
    endtask

    task automatic drive_start(input logic [N-1:0] b, input bit clr);
        @(negedge clk);
        board_in  = b;
        start     = 1'b1;
        score_clr = clr;
        @(posedge clk);
        #1;
        start     = 1'b0;
        score_clr = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_pass(input logic [N-1:0] b, input bit clr);
        int lat;
        push_exp(b, clr);
        drive_start(b, clr);
        check("busy_after_start", busy, 1);
        wait_done(lat);
        check("latency", lat, 22);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    always @(negedge clk) begin
        if (rst && done) begin
            done_cnt++;
            check("pending_exp", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("board", board_out, mon_e.board);
                check("lines", lines_cleared, mon_e.lines);
                check("score", score, mon_e.score);
            end
        end
    end

    initial begin
        logic [N-1:0] b;
        logic [N-1:0] b2;
        int lat;
        int d0;

        #25;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_board", board_out, 0);
        check("rst_lines", lines_cleared, 0);
        check("rst_score", score, 0);
        @(negedge clk);
        rst = 1'b1;

        // single bottom row cleared
        b = '0;
        b = set_row(b, 18, 10'b0010100011);
        b = set_row(b, 19, 10'b1111111111);
        run_pass(b, 1'b0);
        check("t1_row19", board_out[19*COLS +: COLS], 10'b0010100011);
        check("t1_score", score, 1);

        // tetris: four rows
        b = '0;
        for (int r = 16; r < 20; r++) b = set_row(b, r, '1);
        b = set_row(b, 15, 10'd1);
        run_pass(b, 1'b0);
        check("t2_row19", board_out[19*COLS +: COLS], 10'd1);

        // non-contiguous full rows
        b = '0;
        b = set_row(b, 19, '1);
        b = set_row(b, 17, '1);
        b = set_row(b, 18, 10'd1);
        b = set_row(b, 16, 10'd2);
        run_pass(b, 1'b0);
        check("t3_row18", board_out[18*COLS +: COLS], 10'd2);

        // all rows full until the score saturates
        b = '1;
        for (int i = 0; i < 4; i++) run_pass(b, 1'b0);
        check("score_sat", score, SMAX);

        // empty board with score_clr and start together
        run_pass('0, 1'b1);
        check("clr_with_start", score, 0);

        // start and board_in changes mid-pass are ignored
        b = '0;
        b = set_row(b, 19, '1);
        b = set_row(b, 10, 10'b1010101010);
        b = set_row(b, 3, '1);
        b = set_row(b, 2, 10'b0000011111);
        b2 = '1;
        d0 = done_cnt;
        push_exp(b, 1'b0);
        drive_start(b, 1'b0);
        repeat (5) @(negedge clk);
        board_in = b2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("t5_latency", lat, 22 - 6);
        repeat (30) @(negedge clk);
        check("t5_single_done", done_cnt - d0, 1);

        // score_clr alone in idle
        @(negedge clk);
        score_clr = 1'b1;
        @(posedge clk);
        #1;
        score_clr = 1'b0;
        score_model = 0;
        check("score_clr", score, 0);

        // give board_out/score nonzero contents before the abort
        run_pass(b, 1'b0);

        // async reset during SCAN
        push_exp(b, 1'b0);
        drive_start(b, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_board", board_out, 0);
        check("abort_score", score, 0);
        exp_q.delete();
        score_model = 0;
        @(negedge clk);
        rst = 1'b1;
        b = set_row('0, 19, '1);
        b = set_row(b, 12, 10'b0100000010);
        run_pass(b, 1'b0);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
